fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_buf.sv | 76 +++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, instruction field positions
// and the fetch-buffer entry layout.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 11;
  localparam int unsigned OP_EXT_MSB = 1;
  localparam int unsigned OP_EXT_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are 2 bytes wide; the address space wraps at 2^16.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, instr} entries between instruction memory and decode.
// A clear empties it in one cycle and wins over a simultaneous push or pop.
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order memory requests, response buffering, redirect flush and halt.
// Define FETCH_PERF_CNT_EN to add the 32-bit fetch_count output counting delivered instructions.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_inc,
  output logic [4:0]  opcode,
  output logic [1:0]  op_ext
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fsm_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   buf_count;
  logic            buf_full, buf_empty;
  logic            buf_push, buf_pop, buf_clr;
  fetch_entry_t    buf_head, buf_wdata;

  logic            req_fire, rsp_keep;
  logic            redirect_take, halt_take;
  logic [CW:0]     in_use;

  // The entry leaving the buffer this cycle frees its slot for a new request immediately.
  assign in_use = {1'b0, out_q} + {1'b0, buf_count} - (CW+1)'(buf_pop);

  assign imem_req_valid = (state_q != ST_HALT) && (in_use < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = !buf_empty && (state_q != ST_HALT);
  assign buf_pop  = if_valid && !stall;

  assign redirect_take = redirect_valid && (state_q != ST_HALT);
  assign halt_take     = buf_pop && halt && !redirect_valid;
  assign buf_clr       = redirect_take || halt_take;

  assign rsp_keep  = imem_rsp_valid && (state_q == ST_RUN) && !buf_clr;
  assign buf_push  = rsp_keep && (!buf_full || buf_pop);
  assign buf_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};

  assign if_instr  = if_valid ? buf_head.instr : '0;
  assign if_pc     = if_valid ? buf_head.pc    : '0;
  assign if_pc_inc = pc_inc(if_pc);
  assign opcode    = if_instr[OPCODE_MSB:OPCODE_LSB];
  assign op_ext    = if_instr[OP_EXT_MSB:OP_EXT_LSB];

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (buf_clr),
    .push_i      (buf_push),
    .push_data_i (buf_wdata),
    .pop_i       (buf_pop),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  always_comb begin
    out_d = out_q;
    if (req_fire) out_d = out_d + CW'(1);
    if (imem_rsp_valid && (out_q != '0)) out_d = out_d - CW'(1);
  end

  // Responses return in order, so the kept ones carry consecutive PCs starting at the
  // last redirect target; a request accepted in the redirect cycle is itself stale and
  // is therefore counted among those to drop.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    if (req_fire) pc_d = pc_inc(pc_q);
    if (buf_push) rsp_pc_d = pc_inc(rsp_pc_q);
    if (redirect_take) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_d;
      state_d  = (out_d != '0) ? ST_FLUSH : ST_RUN;
    end else if (halt_take) begin
      state_d = ST_HALT;
    end else if ((state_q == ST_FLUSH) && imem_rsp_valid) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fetch_count_q <= '0;
    else if (buf_pop) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
